// File: rtl/processor_pkg.sv
// processor_pkg: opcodes, funct codes, control encodings and the instruction decoder.
// Build option MULT_EN adds mult/multu/mfhi/mflo decoding.
package processor_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03,
    OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
    OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_MFHI = 6'h10, FN_MFLO = 6'h12, FN_MULT = 6'h18,
    FN_MULTU = 6'h19, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
    FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
    ALU_SLT = 3'd4, ALU_SLTU = 3'd5, ALU_LUI = 3'd6, ALU_MUL = 3'd7;
  localparam logic [2:0] BR_NONE = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_LTZ = 3'd3, BR_GEZ = 3'd4;
  localparam logic [2:0] WB_ALU = 3'd0, WB_MEM = 3'd1, WB_LINK = 3'd2, WB_HI = 3'd3, WB_LO = 3'd4;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [4:0] RA = 5'd31;
  typedef struct packed {
    logic reg_write;
    logic [1:0] dst;
    logic use_imm;
    logic zext;
    logic mem_write;
    logic [2:0] br;
    logic jump;
    logic jr;
    logic [2:0] wb;
    logic [2:0] alu;
  } ctrl_t;
  function automatic ctrl_t decode(input logic [5:0] op, input logic [4:0] rt, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.dst = DST_RD;
        c.reg_write = fn inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLTU};
        c.alu = fn inside {FN_SUB, FN_SUBU} ? ALU_SUB : fn == FN_AND ? ALU_AND :
                fn == FN_OR ? ALU_OR : fn == FN_SLT ? ALU_SLT : fn == FN_SLTU ? ALU_SLTU : ALU_ADD;
        c.jr = fn == FN_JR;
`ifdef MULT_EN
        if (fn inside {FN_MULT, FN_MULTU}) c.alu = ALU_MUL;
        if (fn inside {FN_MFHI, FN_MFLO}) begin
          c.reg_write = 1'b1;
          c.wb = fn == FN_MFHI ? WB_HI : WB_LO;
        end
`endif
      end
      OP_REGIMM: c.br = rt == 5'd0 ? BR_LTZ : rt == 5'd1 ? BR_GEZ : BR_NONE;
      OP_J: c.jump = 1'b1;
      OP_JAL: begin
        c.jump = 1'b1;
        c.reg_write = 1'b1;
        c.dst = DST_RA;
        c.wb = WB_LINK;
      end
      OP_BEQ: c.br = BR_EQ;
      OP_BNE: c.br = BR_NE;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
        c.reg_write = 1'b1;
        c.use_imm = 1'b1;
        c.zext = op inside {OP_ANDI, OP_ORI};
        c.wb = op == OP_LW ? WB_MEM : WB_ALU;
        c.alu = op == OP_SLTI ? ALU_SLT : op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR :
                op == OP_LUI ? ALU_LUI : ALU_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.use_imm = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/processor_dp.sv
// processor_dp: PC, register file, ALU, branch/jump resolution and write-back.
// Build option MULT_EN adds the HI/LO registers and the single-cycle multiplier.
module processor_dp
  import processor_pkg::*;
#(
  parameter int IA = 6,
  parameter int DA = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  ctrl_t         ctrl,
  input  logic [25:0]   instr,
  output logic [IA-1:0] imem_addr,
  output logic          mem_write,
  output logic [DA-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  logic [31:0] pc, pc_plus4, rs_val, rt_val, imm, b, alu_y, ext, wdata, next_pc;
  logic [4:0] waddr;
  logic take;
  // State writes are held off while reset is low so preloaded GPRs and RAM survive it.
  processor_regfile gpr (
    .clk(clk), .we(ctrl.reg_write && reset), .ra1(instr[25:21]), .ra2(instr[20:16]),
    .wa(waddr), .wd(wdata), .rd1(rs_val), .rd2(rt_val)
  );
  assign pc_plus4 = pc + 32'd4;
  assign imm = {{16{instr[15] & ~ctrl.zext}}, instr[15:0]};
  assign b = ctrl.use_imm ? imm : rt_val;
  assign alu_y = ctrl.alu == ALU_SUB ? rs_val - b : ctrl.alu == ALU_AND ? rs_val & b :
                 ctrl.alu == ALU_OR ? rs_val | b :
                 ctrl.alu == ALU_SLT ? {31'b0, $signed(rs_val) < $signed(b)} :
                 ctrl.alu == ALU_SLTU ? {31'b0, rs_val < b} :
                 ctrl.alu == ALU_LUI ? {b[15:0], 16'b0} : rs_val + b;
  assign take = (ctrl.br == BR_EQ && rs_val == rt_val) || (ctrl.br == BR_NE && rs_val != rt_val) ||
                (ctrl.br == BR_LTZ && rs_val[31]) || (ctrl.br == BR_GEZ && !rs_val[31]);
  assign next_pc = ctrl.jr ? rs_val : ctrl.jump ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                   take ? pc_plus4 + {imm[29:0], 2'b00} : pc_plus4;
  assign waddr = ctrl.dst == DST_RD ? instr[15:11] : ctrl.dst == DST_RA ? RA : instr[20:16];
  assign wdata = ctrl.wb == WB_MEM ? mem_rdata : ctrl.wb == WB_LINK ? pc_plus4 :
                 ctrl.wb == WB_ALU ? alu_y : ext;
  assign imem_addr = pc[IA+1:2];
  assign mem_addr = alu_y[DA+1:2];
  assign mem_wdata = rt_val;
  assign mem_write = ctrl.mem_write && reset;
  always_ff @(posedge clk or negedge reset)
    if (!reset) pc <= '0;
    else pc <= next_pc;
`ifdef MULT_EN
  logic [31:0] hi, lo;
  logic [63:0] prod;
  logic sx;
  // funct bit 0 clear selects the signed multiply; extending both operands covers both cases.
  assign sx = ~instr[0];
  assign prod = {{32{sx & rs_val[31]}}, rs_val} * {{32{sx & rt_val[31]}}, rt_val};
  always_ff @(posedge clk or negedge reset)
    if (!reset) {hi, lo} <= '0;
    else if (ctrl.alu == ALU_MUL) {hi, lo} <= prod;
  assign ext = ctrl.wb == WB_HI ? hi : lo;
`else
  assign ext = '0;
`endif
endmodule

// File: rtl/processor_regfile.sv
// processor_regfile: 31 writable GPRs with $0 hardwired to zero; 2 async reads, 1 sync write.
module processor_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] registers [1:31];
  always_ff @(posedge clk)
    if (we && wa != 5'd0) registers[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : registers[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : registers[ra2];
endmodule

// File: rtl/processor.sv
// processor: single-cycle MIPS-subset CPU with instruction ROM, data RAM and core.
// Build option MULT_EN enables mult/multu/mfhi/mflo with HI/LO.
module processor_imem #(
  parameter int WORDS = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [AW-1:0] addr,
  output logic [31:0]   instr
);
  logic [31:0] INSTRROM [0:WORDS-1];
  always_ff @(posedge clk)
    if (load) INSTRROM[load_addr] <= load_data;
  assign instr = INSTRROM[addr];
endmodule

module processor_mips
  import processor_pkg::*;
#(
  parameter int IA = 6,
  parameter int DA = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instr,
  output logic [IA-1:0] imem_addr,
  output logic          mem_write,
  output logic [DA-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  ctrl_t ctrl;
  assign ctrl = decode(instr[31:26], instr[20:16], instr[5:0]);
  processor_dp #(.IA(IA), .DA(DA)) dp (
    .clk(clk), .reset(reset), .ctrl(ctrl), .instr(instr[25:0]), .imem_addr(imem_addr),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
endmodule

module processor #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input logic clk,
  input logic reset
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);
  logic [31:0] instr, mem_wdata, mem_rdata;
  logic [IA-1:0] imem_addr;
  logic [DA-1:0] mem_addr;
  logic mem_write;
  logic [31:0] dmem [0:DMEM_WORDS-1];
  // The ROM load port is unused here; program images are placed into INSTRROM from outside.
  processor_imem #(.WORDS(IMEM_WORDS), .AW(IA)) imem (
    .clk(clk), .load(1'b0), .load_addr('0), .load_data('0), .addr(imem_addr), .instr(instr)
  );
  processor_mips #(.IA(IA), .DA(DA)) mips (
    .clk(clk), .reset(reset), .instr(instr), .imem_addr(imem_addr), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always_ff @(posedge clk)
    if (mem_write) dmem[mem_addr] <= mem_wdata;
  assign mem_rdata = dmem[mem_addr];
endmodule

// File: tb/tb_processor.sv
// tb_processor: directed programs for processor; GPRs and PC are checked through the hierarchy.
module tb_processor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int n = 0;
  logic [31:0] prog [0:63];
  processor dut (.clk(clk), .reset(reset));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction
  function automatic logic [31:0] rg(input int k);
    return dut.mips.dp.gpr.registers[k];
  endfunction
  function automatic logic [31:0] pc();
    return dut.mips.dp.pc;
  endfunction

  task automatic emit(input logic [31:0] w);
    prog[n] = w;
    n++;
  endtask

  // Reset, load the pending program and preload all GPRs, then release reset on a falling edge.
  task automatic boot();
    reset = 1'b0;
    for (int k = 0; k < 64; k++) begin
      dut.imem.INSTRROM[k] = prog[k];
      prog[k] = '0;
    end
    for (int k = 1; k < 32; k++) dut.mips.dp.gpr.registers[k] = 32'hCAFEBABE;
    n = 0;
    #1;
    check("reset_pc", pc(), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) prog[k] = '0;
    emit(enc_i(6'h0F, 0, 1, 16'h1234));
    emit(enc_i(6'h0D, 1, 1, 16'h5678));
    emit(enc_i(6'h09, 0, 2, 16'hFFFF));
    boot();
    run(3);
    check("lui_ori", rg(1), 32'h12345678);
    check("addiu_neg", rg(2), 32'hFFFFFFFF);
    check("keep_r3", rg(3), 32'hCAFEBABE);
    check("keep_r31", rg(31), 32'hCAFEBABE);
    check("pc_seq", pc(), 32'hC);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_pc_async", pc(), 32'h0);
    check("rst_keep_r1", rg(1), 32'h12345678);
    @(posedge clk);
    #1;
    check("rst_no_write", rg(1), 32'h12345678);
    check("rst_pc_held", pc(), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    run(1);
    check("rst_restart_r1", rg(1), 32'h12340000);
    check("rst_restart_pc", pc(), 32'h4);
    check("rst_keep_r2", rg(2), 32'hFFFFFFFF);

    emit(enc_i(6'h08, 0, 1, 16'hFFFF));
    emit(enc_i(6'h01, 1, 0, 16'h0001));
    emit(enc_i(6'h08, 0, 2, 16'd5));
    emit(enc_i(6'h08, 0, 3, 16'd7));
    boot();
    run(3);
    check("br_r1", rg(1), 32'hFFFFFFFF);
    check("bltz_skip", rg(2), 32'hCAFEBABE);
    check("br_r3", rg(3), 32'h7);
    check("br_pc", pc(), 32'h10);

    emit(enc_i(6'h08, 0, 4, 16'd3));
    emit(enc_j(6'h03, 26'h4));
    emit(enc_i(6'h08, 0, 5, 16'd9));
    emit(enc_i(6'h04, 0, 0, 16'hFFFF));
    emit(enc_r(6'h08, 31, 0, 0));
    boot();
    run(8);
    check("jal_link", rg(31), 32'h8);
    check("ret_r5", rg(5), 32'h9);
    check("call_r4", rg(4), 32'h3);
    check("self_loop_pc", pc(), 32'hC);

    emit(enc_i(6'h08, 0, 1, 16'd0));
    emit(enc_i(6'h08, 0, 2, 16'd1));
    emit(enc_i(6'h08, 0, 3, 16'd10));
    emit(enc_r(6'h20, 1, 2, 4));
    emit(enc_r(6'h20, 2, 0, 1));
    emit(enc_r(6'h20, 4, 0, 2));
    emit(enc_i(6'h08, 3, 3, 16'hFFFF));
    emit(enc_i(6'h05, 3, 0, 16'hFFFB));
    emit(enc_i(6'h04, 0, 0, 16'hFFFF));
    boot();
    run(60);
    check("fib_f10", rg(1), 32'h37);
    check("fib_f11", rg(2), 32'h59);
    check("fib_count", rg(3), 32'h0);
    check("fib_tmp", rg(4), 32'h59);
    check("fib_pc", pc(), 32'h20);

    emit(enc_i(6'h08, 0, 1, 16'hFFFE));
    emit(enc_i(6'h09, 0, 2, 16'd3));
    emit(enc_r(6'h22, 2, 1, 3));
    emit(enc_r(6'h2A, 1, 2, 4));
    emit(enc_r(6'h2B, 1, 2, 5));
    emit(enc_r(6'h24, 1, 2, 6));
    emit(enc_r(6'h25, 1, 2, 7));
    emit(enc_i(6'h2B, 2, 3, 16'd5));
    emit(enc_i(6'h23, 2, 8, 16'd5));
    emit(enc_i(6'h08, 0, 0, 16'd5));
    emit(32'hFC060001);
    emit(enc_i(6'h05, 3, 8, 16'd5));
    emit(enc_i(6'h01, 1, 1, 16'd5));
    emit(enc_j(6'h02, 26'h10));
    emit(enc_i(6'h08, 0, 9, 16'd1));
    emit(enc_i(6'h08, 0, 9, 16'd2));
    emit(enc_i(6'h0C, 1, 10, 16'hFFF0));
    emit(enc_i(6'h0A, 1, 11, 16'hFFFF));
    emit(enc_r(6'h25, 0, 0, 12));
    emit(enc_i(6'h04, 0, 0, 16'hFFFF));
    boot();
    run(21);
    check("sub", rg(3), 32'h5);
    check("slt", rg(4), 32'h1);
    check("sltu", rg(5), 32'h0);
    check("and_unknown", rg(6), 32'h2);
    check("or", rg(7), 32'hFFFFFFFF);
    check("sw_lw", rg(8), 32'h5);
    check("j_skip", rg(9), 32'hCAFEBABE);
    check("andi_zext", rg(10), 32'h0000FFF0);
    check("slti", rg(11), 32'h1);
    check("zero_reg", rg(12), 32'h0);
    check("misc_pc", pc(), 32'h4C);

    emit(enc_i(6'h08, 0, 1, 16'h4000));
    emit(enc_r(6'h18, 1, 1, 0));
    emit(enc_r(6'h12, 0, 0, 2));
    emit(enc_r(6'h10, 0, 0, 3));
    emit(enc_i(6'h08, 0, 4, 16'hFFFE));
    emit(enc_i(6'h08, 0, 5, 16'd3));
    emit(enc_r(6'h18, 4, 5, 0));
    emit(enc_r(6'h12, 0, 0, 6));
    emit(enc_r(6'h10, 0, 0, 7));
    emit(enc_r(6'h19, 4, 5, 0));
    emit(enc_r(6'h10, 0, 0, 8));
    emit(enc_i(6'h04, 0, 0, 16'hFFFF));
    boot();
    run(14);
`ifdef MULT_EN
    check("mult_lo", rg(2), 32'h10000000);
    check("mult_hi", rg(3), 32'h0);
    check("mult_neg_lo", rg(6), 32'hFFFFFFFA);
    check("mult_neg_hi", rg(7), 32'hFFFFFFFF);
    check("multu_hi", rg(8), 32'h2);
`else
    check("nomult_r2", rg(2), 32'hCAFEBABE);
    check("nomult_r3", rg(3), 32'hCAFEBABE);
    check("nomult_r6", rg(6), 32'hCAFEBABE);
    check("nomult_r8", rg(8), 32'hCAFEBABE);
`endif
    check("mult_r4", rg(4), 32'hFFFFFFFE);
    check("mult_pc", pc(), 32'h2C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
